// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud divisor, frame format and FSM states.
// The receiver imports the same package so both sides agree on timing.
package uart_pkg;

    // 50 MHz system clock / 9600 baud
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

    // Baud counter width; covers divisors up to 8191
    localparam int BAUD_CNT_W = 13;

    // Data bits per frame (8N1 style payload)
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Modulo-N clock-cycle counter with enable and a wrap pulse.
// Held at zero while disabled so every bit period starts from a clean count.
module uart_baud_cnt #(
    parameter int N = 5208,
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_reg;

    // Count 0..N-1 while enabled, restart at 0 on each bit boundary
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign wrap  = en && (count_reg == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: LSB first, optional parity, 1 or 2 stop bits.
// One byte is accepted per valid/ready handshake; the line output is registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_uart,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]            DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic                  LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic                  PAR_INV   = 1'(PARITY_ODD);

    uart_state_t           state_reg;
    logic [7:0]            shift_reg;
    logic [2:0]            bit_idx_reg;
    logic                  stop_idx_reg;
    logic                  parity_reg;
    logic                  tx_uart_reg;
    logic [BAUD_CNT_W-1:0] bit_cnt;
    logic                  bit_wrap;
    logic [7:0]            par_chain;

    // Running XOR across the incoming byte; par_chain[7] is its even parity
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_par
            if (gi == 0) begin : g_first
                assign par_chain[gi] = tx_data[gi];
            end else begin : g_rest
                assign par_chain[gi] = par_chain[gi-1] ^ tx_data[gi];
            end
        end
    endgenerate

    uart_baud_cnt #(
        .N (CLKS_PER_BIT),
        .W (BAUD_CNT_W)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .en    (state_reg != IDLE),
        .count (bit_cnt),
        .wrap  (bit_wrap)
    );

    // Frame sequencer: the line value is loaded on entry to each bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            parity_reg   <= 1'b0;
            tx_uart_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_uart_reg <= 1'b1;
                    if (tx_valid) begin
                        shift_reg   <= tx_data;
                        parity_reg  <= par_chain[7] ^ PAR_INV;
                        tx_uart_reg <= 1'b0;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (bit_wrap) begin
                        tx_uart_reg <= shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_wrap) begin
                        if (bit_idx_reg == DATA_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_uart_reg <= parity_reg;
                                state_reg   <= PARITY;
                            end else begin
                                tx_uart_reg  <= 1'b1;
                                stop_idx_reg <= 1'b0;
                                state_reg    <= STOP;
                            end
                        end else begin
                            tx_uart_reg <= shift_reg[0];
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_wrap) begin
                        tx_uart_reg  <= 1'b1;
                        stop_idx_reg <= 1'b0;
                        state_reg    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_wrap) begin
                        if (stop_idx_reg == LAST_STOP) begin
                            tx_uart_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_uart_reg <= 1'b1;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = (state_reg == IDLE);
    assign tx_busy  = (state_reg != IDLE);
    assign tx_uart  = tx_uart_reg;
    // Final cycle of the last stop bit
    assign tx_done  = (state_reg == STOP) && (stop_idx_reg == LAST_STOP) && (bit_cnt == BIT_LAST);

endmodule
